dac_baseline_cal: RTL and testbench

- Calibration initiator for the ADC baseline measurement path.
- Runs a successive-approximation (SAR) search over the front-end offset DAC code until the measured ADC baseline is as close to `target` as possible without exceeding it.
- Drives the DAC code and the `dacset` handshake into the baseline measurement block, and consumes that block's `baseline`/`done` outputs.
- Sits between the run-control register interface and the DAC serial writer.

---
 rtl/dac_baseline_cal.sv | 211 +++++++++++++++++++++
 tb/tb_dac_baseline_cal.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_baseline_cal.sv
// dac_baseline_cal: SAR search over the front-end offset DAC code so the measured
// ADC baseline lands as close to the target as possible without exceeding it.
// Drives dac_code/dacset into the baseline measurement block and consumes its
// bl_baseline/bl_done outputs.
// Optional feature macro: CAL_TOL_EN adds a tolerance input that lets the search stop
// early once the measurement is within tol counts of the target.

module dac_baseline_cal #(
    parameter int unsigned DACW   = 12,
    parameter int unsigned SETTLE = 64,
    parameter int unsigned TMO_W  = 12,
    parameter bit          INV    = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [13:0]     target,
`ifdef CAL_TOL_EN
    input  logic [7:0]      tol,
`endif
    input  logic [13:0]     bl_baseline,
    input  logic            bl_done,
    output logic            dacset,
    output logic [DACW-1:0] dac_code,
    output logic            dac_wr,
    output logic            busy,
    output logic            cal_done,
    output logic            cal_err,
    output logic [13:0]     cal_baseline
);

    localparam int unsigned IW = (DACW > 1) ? $clog2(DACW) : 1;
    localparam int unsigned SW = $clog2(SETTLE);

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    // Counter value on the last allowed REL/MEAS cycle; the next increment would
    // reach 2^TMO_W-1.
    localparam logic [TMO_W-1:0] TMO_LAST    = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StRel,
        StMeas,
        StDec,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [13:0]       target_q, target_d;
    logic [DACW-1:0]   code_q, code_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              final_q, final_d;
    logic [13:0]       meas_q, meas_d;
    logic [13:0]       base_q, base_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [IW-1:0]     idx_m1;
    logic              hi;
    logic              stop_now;

`ifdef CAL_TOL_EN
    logic [7:0]        tol_q, tol_d;
    logic [14:0]       diff;

    // Absolute distance between the latest measurement and the target
    always_comb begin
        if (meas_q >= target_q) begin
            diff = {1'b0, meas_q} - {1'b0, target_q};
        end else begin
            diff = {1'b0, target_q} - {1'b0, meas_q};
        end
    end

    assign stop_now = final_q || (diff <= {7'b0, tol_q});
`else
    assign stop_now = final_q;
`endif

    // With inverted polarity the "too high" test flips sides; equality keeps the bit
    // in both polarities.
    assign hi     = INV ? (meas_q < target_q) : (meas_q > target_q);
    assign idx_m1 = idx_q - 1'b1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            target_q <= '0;
            code_q   <= '0;
            idx_q    <= IW'(DACW - 1);
            final_q  <= 1'b0;
            meas_q   <= '0;
            base_q   <= '0;
            scnt_q   <= '0;
            tmo_q    <= '0;
`ifdef CAL_TOL_EN
            tol_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            final_q  <= final_d;
            meas_q   <= meas_d;
            base_q   <= base_d;
            scnt_q   <= scnt_d;
            tmo_q    <= tmo_d;
`ifdef CAL_TOL_EN
            tol_q    <= tol_d;
`endif
        end
    end

    // Next-state logic: start handling, settle/timeout counting and the SAR step
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        code_d   = code_q;
        idx_d    = idx_q;
        final_d  = final_q;
        meas_d   = meas_q;
        base_d   = base_q;
        scnt_d   = scnt_q;
        tmo_d    = tmo_q;
`ifdef CAL_TOL_EN
        tol_d    = tol_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    target_d         = target;
`ifdef CAL_TOL_EN
                    tol_d            = tol;
`endif
                    code_d           = '0;
                    code_d[DACW-1]   = 1'b1;
                    idx_d            = IW'(DACW - 1);
                    final_d          = 1'b0;
                    scnt_d           = '0;
                    state_d          = StSet;
                end
            end
            StSet: begin
                if (scnt_q == SETTLE_LAST) begin
                    scnt_d  = '0;
                    tmo_d   = '0;
                    state_d = StRel;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            StRel: begin
                // Wait for the stale done of the previous measurement to clear
                if (tmo_q == TMO_LAST) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (!bl_done) begin
                        state_d = StMeas;
                    end
                end
            end
            StMeas: begin
                if (tmo_q == TMO_LAST) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (bl_done) begin
                        meas_d  = bl_baseline;
                        state_d = StDec;
                    end
                end
            end
            StDec: begin
                if (stop_now) begin
                    base_d  = meas_q;
                    state_d = StDone;
                end else begin
                    if (hi) begin
                        code_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        code_d[idx_m1] = 1'b1;
                        idx_d          = idx_m1;
                    end else begin
                        final_d = 1'b1;
                    end
                    scnt_d  = '0;
                    state_d = StSet;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state so an async reset clears them immediately
    always_comb begin
        dacset       = (state_q == StSet);
        dac_wr       = (state_q == StSet) && (scnt_q == '0);
        busy         = (state_q == StSet) || (state_q == StRel) ||
                       (state_q == StMeas) || (state_q == StDec);
        cal_done     = (state_q == StDone);
        cal_err      = (state_q == StErr);
        dac_code     = code_q;
        cal_baseline = base_q;
    end

endmodule

// File: tb/tb_dac_baseline_cal.sv
// Bench for dac_baseline_cal: two instances (INV=0 and INV=1), each with a model of
// the baseline measurement block, and a scoreboard of expected calibration results.
module tb_dac_baseline_cal;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [13:0] tgt_a = '0, tgt_b = '0;
    logic [13:0] bl_base_a, bl_base_b;
    logic        bl_done_a, bl_done_b;
    logic        dacset_a, dacset_b, wr_a, wr_b, busy_a, busy_b;
    logic        done_a, done_b, err_a, err_b;
    logic [11:0] code_a, code_b;
    logic [13:0] calb_a, calb_b;
    logic        stall = 1'b0;
`ifdef CAL_TOL_EN
    logic [7:0]  tol = '0;
`endif

    dac_baseline_cal u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .target(tgt_a),
`ifdef CAL_TOL_EN
        .tol(tol),
`endif
        .bl_baseline(bl_base_a), .bl_done(bl_done_a), .dacset(dacset_a),
        .dac_code(code_a), .dac_wr(wr_a), .busy(busy_a), .cal_done(done_a),
        .cal_err(err_a), .cal_baseline(calb_a)
    );

    dac_baseline_cal #(.INV(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .target(tgt_b),
`ifdef CAL_TOL_EN
        .tol(tol),
`endif
        .bl_baseline(bl_base_b), .bl_done(bl_done_b), .dacset(dacset_b),
        .dac_code(code_b), .dac_wr(wr_b), .busy(busy_b), .cal_done(done_b),
        .cal_err(err_b), .cal_baseline(calb_b)
    );

    function automatic int model_a(int c);
        int v;
        v = 1000 + 2 * c;
        if (v > 16383) v = 16383;
        return v;
    endfunction

    function automatic int model_b(int c);
        return 9190 - 2 * c;
    endfunction

    // Brute-force reference: best code satisfying the polarity's bound
    function automatic int best_code(bit inv, int tgt);
        int best;
        best = 0;
        for (int c = 0; c < 4096; c++) begin
            if (!inv && model_a(c) <= tgt) best = c;
            if (inv && model_b(c) >= tgt) best = c;
        end
        return best;
    endfunction

    // Measurement block models: done drops 1 cycle after dacset falls, rises 8 later
    logic dsp_a, dsp_b;
    int   mc_a, mc_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a <= 1'b0; mc_a <= 0; bl_done_a <= 1'b1; bl_base_a <= '0;
        end else begin
            dsp_a <= dacset_a;
            if (dsp_a && !dacset_a) begin
                bl_done_a <= 1'b0;
                mc_a      <= 8;
            end else if (mc_a > 0) begin
                mc_a <= mc_a - 1;
                if (mc_a == 1 && !stall) begin
                    bl_done_a <= 1'b1;
                    bl_base_a <= 14'(model_a(int'(code_a)));
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_b <= 1'b0; mc_b <= 0; bl_done_b <= 1'b1; bl_base_b <= '0;
        end else begin
            dsp_b <= dacset_b;
            if (dsp_b && !dacset_b) begin
                bl_done_b <= 1'b0;
                mc_b      <= 8;
            end else if (mc_b > 0) begin
                mc_b <= mc_b - 1;
                if (mc_b == 1) begin
                    bl_done_b <= 1'b1;
                    bl_base_b <= 14'(model_b(int'(code_b)));
                end
            end
        end
    end

    // Activity counters, cleared by an accepted start
    int wr_cnt_a, wr_cnt_b, rm_cnt_a;
    always @(negedge clk) begin
        if (start_a && !busy_a) begin
            wr_cnt_a <= 0; rm_cnt_a <= 0;
        end else begin
            if (wr_a) wr_cnt_a <= wr_cnt_a + 1;
            if (busy_a && !dacset_a) rm_cnt_a <= rm_cnt_a + 1;
        end
        if (start_b && !busy_b) wr_cnt_b <= 0;
        else if (wr_b) wr_cnt_b <= wr_cnt_b + 1;
    end

    typedef struct {
        int code;
        int base;
        int nwr;
        bit err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_a(input int tgt);
        @(posedge clk); #1;
        tgt_a   = 14'(tgt);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic pulse_b(input int tgt);
        @(posedge clk); #1;
        tgt_b   = 14'(tgt);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic push(input bit sel, input int code, input int base, input int nwr,
                        input bit err);
        exp_t e;
        e.code = code; e.base = base; e.nwr = nwr; e.err = err;
        if (sel) q_b.push_back(e);
        else q_a.push_back(e);
    endtask

    task automatic wait_end(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (!sel && (done_a || err_a)) seen = 1'b1;
            if (sel && (done_b || err_b)) seen = 1'b1;
        end
        chk("end_seen", int'(seen), 1);
    endtask

    task automatic pop_cmp(input bit sel);
        exp_t e;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sel ? q_b.pop_front() : q_a.pop_front();
        if (!sel) begin
            chk("code_a", int'(code_a), e.code);
            chk("err_a", int'(err_a), int'(e.err));
            chk("done_a", int'(done_a), int'(!e.err));
            chk("busy_a", int'(busy_a), 0);
            if (!e.err) chk("calb_a", int'(calb_a), e.base);
            if (e.nwr > 0) chk("nwr_a", wr_cnt_a, e.nwr);
        end else begin
            chk("code_b", int'(code_b), e.code);
            chk("calb_b", int'(calb_b), e.base);
            chk("done_b", int'(done_b), 1);
            chk("busy_b", int'(busy_b), 0);
            if (e.nwr > 0) chk("nwr_b", wr_cnt_b, e.nwr);
        end
    endtask

    task automatic run_a(input int tgt);
        int c;
        int nwr;
        c = best_code(1'b0, tgt);
`ifdef CAL_TOL_EN
        nwr = 0;
`else
        nwr = 13;
`endif
        push(1'b0, c, model_a(c), nwr, 1'b0);
        pulse_a(tgt);
        wait_end(1'b0);
        pop_cmp(1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_dacset", int'(dacset_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_code", int'(code_a), 0);
        chk("rst_wr", int'(wr_a), 0);
        chk("rst_calb", int'(calb_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while settling
        pulse_a(5000);
        repeat (10) @(negedge clk);
        chk("midset_dacset_pre", int'(dacset_a), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midset_dacset", int'(dacset_a), 0);
        chk("midset_busy", int'(busy_a), 0);
        chk("midset_done", int'(done_a), 0);
        chk("midset_err", int'(err_a), 0);
        chk("midset_code", int'(code_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Normal search and bounds
        run_a(5000);
        chk("normal_code_const", int'(code_a), 2000);
        run_a(900);
        run_a(16383);
        chk("top_calb_const", int'(calb_a), 9190);

        // Timeout, with an ignored start while busy
        stall = 1'b1;
        push(1'b0, 2048, 0, 1, 1'b1);
        pulse_a(5000);
        repeat (20) @(negedge clk);
        pulse_a(900);
        repeat (100) @(negedge clk);
        chk("busy_start_code", int'(code_a), 2048);
        chk("busy_start_busy", int'(busy_a), 1);
        wait_end(1'b0);
        chk("tmo_dacset", int'(dacset_a), 0);
        chk("tmo_cycles", rm_cnt_a, 4095);
        pop_cmp(1'b0);
        stall = 1'b0;

        // Recovery after an error
        run_a(5000);

        // Inverted polarity, then back-to-back start from DONE
        push(1'b1, best_code(1'b1, 5000), model_b(best_code(1'b1, 5000)), 0, 1'b0);
        pulse_b(5000);
        wait_end(1'b1);
        chk("inv_code_const", int'(code_b), 2095);
        pop_cmp(1'b1);
        push(1'b1, best_code(1'b1, 7000), model_b(best_code(1'b1, 7000)), 0, 1'b0);
        @(posedge clk); #1;
        tgt_b   = 14'd7000;
        start_b = 1'b1;
        @(negedge clk);
        chk("b2b_busy_pre", int'(busy_b), 0);
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("b2b_done_clr", int'(done_b), 0);
        chk("b2b_busy", int'(busy_b), 1);
        wait_end(1'b1);
        pop_cmp(1'b1);

`ifdef CAL_TOL_EN
        tol = 8'd64;
        push(1'b0, 1984, 4968, 6, 1'b0);
        pulse_a(5000);
        wait_end(1'b0);
        pop_cmp(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
